// File: rtl/button_debounce_pkg.sv
// Shared types for the push-button conditioner: FSM state encoding and
// the dwell-counter width helper.
package button_pkg;

  typedef enum logic [1:0] {
    REL_STABLE,
    PRESS_CHECK,
    PRS_STABLE,
    REL_CHECK
  } btn_state_e;

  // Width of a counter that must reach cycles-1; never narrower than 1 bit.
  function automatic int dwell_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Signal bundle between the button pad side and the debounced consumers.
// press_cnt_o exists only when BUTTON_PRESS_COUNT_EN is defined.
interface button_debounce_if #(
  parameter int CNT_W = 16
);
  logic             enable_i;
  logic             btn_i;
  logic             btn_o;
  logic             press_o;
  logic             release_o;
`ifdef BUTTON_PRESS_COUNT_EN
  logic [CNT_W-1:0] press_cnt_o;
`endif

  // Drives the raw pad / enable, observes the conditioned outputs.
  modport master (
    output enable_i, btn_i,
`ifdef BUTTON_PRESS_COUNT_EN
    input  press_cnt_o,
`endif
    input  btn_o, press_o, release_o
  );

  // The debouncer itself.
  modport slave (
    input  enable_i, btn_i,
`ifdef BUTTON_PRESS_COUNT_EN
    output press_cnt_o,
`endif
    output btn_o, press_o, release_o
  );
endinterface

// File: rtl/button_sync.sv
// Multi-flop synchroniser for an asynchronous pad input; clears to 0.
module button_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the pad level through the flop chain, oldest sample at the top.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce with a dwell counter,
// emit a clean level plus one-cycle press/release strobes.
// Optional press counter enabled by defining BUTTON_PRESS_COUNT_EN.
module button_debounce
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int CNT_W           = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  button_debounce_if.slave bus
);

  localparam int             CW      = dwell_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s;
  btn_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          btn_q, press_q, release_q;

  button_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .d_i    (bus.btn_i ^ ACTIVE_LOW),
    .q_o    (s)
  );

  // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive enabled cycles of the new synchronised level.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= REL_STABLE;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (!bus.enable_i) begin
        // Disable abandons any pending change, even on the accepting cycle.
        cnt_q <= '0;
        if (state_q == PRESS_CHECK)    state_q <= REL_STABLE;
        else if (state_q == REL_CHECK) state_q <= PRS_STABLE;
      end else begin
        unique case (state_q)
          REL_STABLE: begin
            if (s) begin
              state_q <= PRESS_CHECK;
              cnt_q   <= CW'(1);
            end else begin
              cnt_q   <= '0;
            end
          end
          PRESS_CHECK: begin
            if (!s) begin
              state_q <= REL_STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_MAX) begin
              state_q <= PRS_STABLE;
              btn_q   <= 1'b1;
              press_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
            end
          end
          PRS_STABLE: begin
            if (!s) begin
              state_q <= REL_CHECK;
              cnt_q   <= CW'(1);
            end else begin
              cnt_q   <= '0;
            end
          end
          REL_CHECK: begin
            if (s) begin
              state_q   <= PRS_STABLE;
              cnt_q     <= '0;
            end else if (cnt_q == CNT_MAX) begin
              state_q   <= REL_STABLE;
              btn_q     <= 1'b0;
              release_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              cnt_q     <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= REL_STABLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.btn_o     = btn_q;
  assign bus.press_o   = press_q;
  assign bus.release_o = release_q;

`ifdef BUTTON_PRESS_COUNT_EN
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

  // Count follows the strobe by one cycle; wraps freely.
  always_comb begin
    press_cnt_d = press_cnt_q;
    if (press_q) press_cnt_d = press_cnt_q + 1'b1;
  end

  // Press count register, cleared only by reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) press_cnt_q <= '0;
    else            press_cnt_q <= press_cnt_d;
  end

  assign bus.press_cnt_o = press_cnt_q;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with a run-length reference model.
// Press-counter checks compile in when BUTTON_PRESS_COUNT_EN is defined.
module tb_button_debounce;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_on = 1'b0;

  button_debounce_if #(.CNT_W(CW)) bus ();

  button_debounce #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b0), .CNT_W(CW)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Reference: s is the pad delayed SYNC edges; the level flips once the
  // enabled run of cycles where s differs from it reaches DEB.
  bit m_dly[SYNC];
  bit m_lvl, m_prs, m_rel, m_s;
  int m_run, m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_dly[i] = 1'b0;
      m_lvl = 0; m_prs = 0; m_rel = 0; m_run = 0; m_cnt = 0;
    end else begin
      m_s = m_dly[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_dly[i] = m_dly[i-1];
      m_dly[0] = bus.btn_i;
      if (m_prs) m_cnt = (m_cnt + 1) % (1 << CW);
      m_prs = 0; m_rel = 0;
      if (bus.enable_i && m_s != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl = m_s; m_run = 0;
          if (m_s) m_prs = 1; else m_rel = 1;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("btn_o",     int'(bus.btn_o),     int'(m_lvl));
      chk("press_o",   int'(bus.press_o),   int'(m_prs));
      chk("release_o", int'(bus.release_o), int'(m_rel));
`ifdef BUTTON_PRESS_COUNT_EN
      chk("press_cnt_o", int'(bus.press_cnt_o), m_cnt);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.enable_i = 1'b1; bus.btn_i = 1'b0;
    tick(3);
    chk("reset btn_o",     int'(bus.btn_o),     0);
    chk("reset press_o",   int'(bus.press_o),   0);
    chk("reset release_o", int'(bus.release_o), 0);
`ifdef BUTTON_PRESS_COUNT_EN
    chk("reset press_cnt_o", int'(bus.press_cnt_o), 0);
`endif
    rst_n = 1'b1; cmp_on = 1'b1;
    tick(2);

    // Clean press, held 10 cycles.
    bus.btn_i = 1'b1;
    tick(5);
    chk("press edge5 btn_o", int'(bus.btn_o), 0);
    tick(1);
    chk("press edge6 btn_o",   int'(bus.btn_o),   1);
    chk("press edge6 press_o", int'(bus.press_o), 1);
    tick(1);
    chk("press edge7 press_o", int'(bus.press_o), 0);
`ifdef BUTTON_PRESS_COUNT_EN
    chk("press edge7 cnt", int'(bus.press_cnt_o), 1);
`endif
    tick(3);

    // Clean release.
    bus.btn_i = 1'b0;
    tick(5);
    chk("release edge5 btn_o", int'(bus.btn_o), 1);
    tick(1);
    chk("release edge6 btn_o",     int'(bus.btn_o),     0);
    chk("release edge6 release_o", int'(bus.release_o), 1);
    tick(1);
    chk("release edge7 release_o", int'(bus.release_o), 0);
    tick(3);

    // Release glitch of 2 cycles while pressed is ignored.
    bus.btn_i = 1'b1; tick(8);
    bus.btn_i = 1'b0; tick(2);
    bus.btn_i = 1'b1; tick(8);
    chk("rel glitch btn_o", int'(bus.btn_o), 1);
    bus.btn_i = 1'b0; tick(8);

    // Bounce: 3-cycle pulse rejected, then a 4+ cycle hold accepted.
    bus.btn_i = 1'b1; tick(3);
    bus.btn_i = 1'b0; tick(8);
    chk("bounce btn_o", int'(bus.btn_o), 0);
    bus.btn_i = 1'b1; tick(5);
    chk("bounce2 edge5 btn_o", int'(bus.btn_o), 0);
    tick(1);
    chk("bounce2 edge6 press_o", int'(bus.press_o), 1);
    bus.btn_i = 1'b0; tick(8);

    // Enable gating from PRESS_CHECK with cnt=2.
    bus.btn_i = 1'b1; tick(4);
    bus.enable_i = 1'b0; tick(3);
    chk("disabled btn_o", int'(bus.btn_o), 0);
    bus.enable_i = 1'b1; tick(3);
    chk("reenable 3 btn_o", int'(bus.btn_o), 0);
    tick(1);
    chk("reenable 4 btn_o",   int'(bus.btn_o),   1);
    chk("reenable 4 press_o", int'(bus.press_o), 1);
    bus.btn_i = 1'b0; tick(8);

    // Reset mid-check with the button held.
    bus.btn_i = 1'b1; tick(4);
    rst_n = 1'b0; tick(1);
    chk("midrst btn_o",   int'(bus.btn_o),   0);
    chk("midrst press_o", int'(bus.press_o), 0);
    rst_n = 1'b1; tick(5);
    chk("postrst edge5 press_o", int'(bus.press_o), 0);
    tick(1);
    chk("postrst edge6 press_o", int'(bus.press_o), 1);
    bus.btn_i = 1'b0; tick(8);

`ifdef BUTTON_PRESS_COUNT_EN
    // Counter wrap: 16 presses from a freshly reset count.
    rst_n = 1'b0; tick(1);
    rst_n = 1'b1; tick(1);
    for (int i = 0; i < 16; i++) begin
      bus.btn_i = 1'b1; tick(7);
      bus.btn_i = 1'b0; tick(7);
      if (i == 14) chk("wrap cnt after 15", int'(bus.press_cnt_o), 15);
      if (i == 15) chk("wrap cnt after 16", int'(bus.press_cnt_o), 0);
    end
`endif

    cmp_on = 1'b0;
    tick(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/button_debounce.md
# button_debounce

Front-end conditioner for a mechanical push-button on a user-area GPIO. It synchronises the raw pad input into the Wishbone clock domain and filters contact bounce with a per-state dwell counter. It produces a clean level plus one-cycle press/release strobes. It sits directly upstream of the button-to-LED output stage, which consumes `btn_o` in place of the raw pad bit.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the input synchroniser; legal range ≥2.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable synchronised cycles required to accept a change; legal range ≥2.
- `ACTIVE_LOW`, 0: when 1, `btn_i` is inverted before synchronisation, so a pad at 0 means pressed.
- `CNT_W`, 16: width of the press counter. Used only with `BUTTON_PRESS_COUNT_EN`.

- `wb_clk_i` in 1: the single clock.
- `wb_rst_ni` in 1: reset, synchronous, active-low.
- `enable_i` in 1: filter enable. When low, the state is frozen and the dwell counter is cleared.
- `btn_i` in 1: raw asynchronous pad input, driven from `io_in[3]`.
- `btn_o` out 1: debounced level, 1 = pressed.
- `press_o` out 1: one-cycle strobe, asserted in the cycle `btn_o` rises.
- `release_o` out 1: one-cycle strobe, asserted in the cycle `btn_o` falls.
- `press_cnt_o` out CNT_W: count of accepted presses. Present only with `BUTTON_PRESS_COUNT_EN`.

## Operation
- Conditioning: the raw input is XOR'd with `ACTIVE_LOW`, then passes through a `SYNC_STAGES`-deep synchroniser to give `s`. The synchroniser resets to 0.
- FSM states: `REL_STABLE`, `PRESS_CHECK`, `PRS_STABLE`, `REL_CHECK`. Reset state is `REL_STABLE`.
- Dwell counter `cnt` has width $clog2(DEBOUNCE_CYCLES). It resets to 0.
- `REL_STABLE`:
  - `s`=1 → `PRESS_CHECK` with `cnt`<=1.
  - Otherwise hold, with `cnt`=0.
- `PRESS_CHECK`:
  - `s`=0 → `REL_STABLE` with `cnt`<=0. The glitch is rejected and no strobe is issued.
  - `s`=1 and `cnt`==DEBOUNCE_CYCLES-1 → `PRS_STABLE`, `btn_o`<=1, `press_o`<=1, `cnt`<=0.
  - Otherwise `cnt`<=`cnt`+1.
- `PRS_STABLE` and `REL_CHECK` mirror the two states above with `s` inverted. Acceptance sets `btn_o`<=0 and `release_o`<=1.
- Strobes are registered and high for exactly one cycle. They can never both be high in the same cycle.
- `enable_i`=0:
  - A CHECK state returns to its STABLE state, and `cnt`<=0.
  - `btn_o` holds and no strobes are issued.
  - The synchroniser keeps running.
  - If `enable_i`=0 and acceptance coincide in the same cycle, disable wins.
- Reset mid-check:
  - All outputs and the counter clear.
  - A pending change is discarded.
  - A button held across reset is re-qualified from `REL_STABLE`, and a `press_o` follows after the full latency.

## Timing
- Reset values: `btn_o`=0, `press_o`=0, `release_o`=0, `press_cnt_o`=0.
- Edges are counted from the first rising edge that samples the new `btn_i` level (edge 1).
- `s` changes after edge SYNC_STAGES.
- `btn_o` and the strobe change at edge SYNC_STAGES+DEBOUNCE_CYCLES, provided `btn_i` holds steady throughout.
- Shortest accepted pulse: DEBOUNCE_CYCLES cycles of stable `s`. Any shorter excursion produces no output activity.
- No combinational path from `btn_i` or `enable_i` to any output.

## Configuration
- `BUTTON_PRESS_COUNT_EN` defined:
  - A CNT_W-bit register increments in the cycle `press_o` is asserted. The incremented value is visible the cycle after the strobe.
  - It wraps modulo 2^CNT_W (all-ones → 0) with no saturation.
  - It clears only on reset.
  - It drives `press_cnt_o` for readout over the logic analyser.
- Undefined: the `press_cnt_o` port and the register do not exist. All other behaviour is identical.

## Structure
- Package `button_pkg`: the FSM state enum, plus the localparam helper for the dwell-counter width.
- Sub-module `button_sync`: a parameterised `SYNC_STAGES` flop chain with synchronous active-low reset. The top module holds the FSM, the counter, the strobes and the optional press counter.

## Test plan
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=0, CNT_W=4.
- Clean press: `btn_i` 0→1, held for 10 cycles.
  - `btn_o` rises at edge 6.
  - `press_o` is high for exactly one cycle, at edge 6.
  - `press_cnt_o` goes 0→1 one cycle after the strobe.
- Bounce rejection:
  - `btn_i` high for 3 cycles, then low → `btn_o` stays 0, no strobes.
  - Then high for 4 or more cycles → accepted at edge 6 from the final rise.
- Release: from the pressed state, drop `btn_i` and hold → `btn_o` falls at edge 6 and `release_o` pulses once. A release glitch of 2 cycles is ignored.
- Enable gating: deassert `enable_i` while in `PRESS_CHECK` with `cnt`=2 → no strobe. Re-enable with `btn_i` still high → acceptance after 4 further `s`=1 cycles.
- Reset mid-check: assert `wb_rst_ni`=0 for 1 cycle during `PRESS_CHECK` → all outputs 0. With `btn_i` still high, `press_o` follows 6 edges after reset release.
- Counter wrap (macro on): 16 accepted presses → `press_cnt_o` reads 15 after the 15th and 0 after the 16th.
